mux_select_arbiter: RTL and testbench
=====================================

// Module: mux_select_arbiter
// PURPOSE
//  Clocked round-robin arbiter that sequences the 2-input PCHB mux by generating its select token stream.
//  Watches request/tail flags from the two input buffers feeding mux data ports 0/1.
//  Emits one dual-rail 1-of-2 select token per flit on the mux SELECT channel, using the 4-phase enable handshake.
//  Holds a grant for a whole packet (until the tail flit or a burst limit), then rotates priority.
//  Sits beside the mux in each router output port; it is the only driver of the mux select channel.
// PARAMETERS
//  MAX_BURST  16    max tokens per grant before forced release (>=1)
//  CNT_W      5     width of burst/token counter; must satisfy 2**CNT_W > MAX_BURST
//  TIMEOUT    255   cycles in SEND without consume before err_timeout sets (0 = check disabled)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high; also resets the mux (shared net)
//  req          in   2      req[i]=1: input i holds a flit waiting for mux port i
//  tail         in   2      tail[i]=1: the waiting flit on input i is the last of its packet
//  sel_r        out  2      dual-rail select token: 01 = choose port 0, 10 = choose port 1, 00 = neutral
//  sel_e        in   1      mux select-channel enable (async): 1 = ready for token, 0 = token consumed
//  grant        out  2      one-hot current packet owner; 00 when idle
//  busy         out  1      1 in any state other than IDLE
//  tok_cnt      out  CNT_W  tokens issued in the current grant
//  err_timeout  out  1      sticky; set when SEND lasts TIMEOUT cycles; cleared only by reset
// BEHAVIOUR
//  Reset (async): state=IDLE; sel_r=00; grant=00; busy=0; tok_cnt=0; err_timeout=0; last_ptr=1, so port 0 wins the first tie.
//  sel_e passes through a 2-FF synchronizer (sel_e_s), reset to 0. Every handshake decision uses sel_e_s only.
//  All outputs are registered; there are no combinational paths from inputs to outputs.
//  States:
//   IDLE: sel_r=00. If req!=0 and sel_e_s=1:
//     - win = the only requester; or, if req=11, win = ~last_ptr.
//     - grant<=onehot(win); tok_cnt<=0; go SEND.
//     - sel_r<=onehot(win) on the same edge (1 cycle from decision).
//   SEND: sel_r is held stable until sel_e_s=0 (token consumed). On that edge:
//     - sel_r<=00; tok_cnt<=tok_cnt+1.
//     - release = tail[win] | (tok_cnt+1==MAX_BURST), sampled on the same edge.
//     - go RTZ.
//   RTZ: sel_r=00; wait for sel_e_s=1, then:
//     - if release | ~req[win]: grant<=00; last_ptr<=win; go IDLE.
//     - else: sel_r<=onehot(win); go SEND. Same owner; no re-arbitration mid-packet.
//  Handshake rules:
//   - sel_r never changes from one non-neutral code directly to another; 00 always sits between tokens.
//   - sel_r is never 11.
//  Latencies:
//   - IDLE decision to token: 1 cycle.
//   - sel_e edge seen: 2 cycles (synchronizer).
//   - Minimum token period: 1 (issue) + 2 (sync fall) + 1 (RTZ) + 2 (sync rise) cycles.
//  Boundary conditions:
//   - req[win] dropping during SEND: token held, no withdrawal; release handled in RTZ.
//   - Both req rising in the same cycle: ~last_ptr wins; the loser waits at most one packet.
//   - tok_cnt saturates at MAX_BURST and is never above it.
//   - MAX_BURST=1: every token is a release, giving flit-level round robin.
//   - SEND timer counts cycles in SEND and resets on entry. When it reaches TIMEOUT, err_timeout<=1 and the FSM keeps waiting.
//   - Reset mid-token: sel_r goes to 00 immediately. The mux is reset on the same net, so no orphan handshake is left.
//   - tail[] is ignored outside the SEND consume edge.
// TESTING
//  1. Only req=01, tail=1 on first flit -> one token sel_r=01; grant 01->00; last_ptr=0; busy returns 0.
//  2. req=11 out of reset, tail on 3rd flit of each -> sel_r tokens 01,01,01 then 10,10,10; 00 between every token.
//  3. req held on port 1, tail never set, MAX_BURST=4 -> 4 tokens of 10, release; if req=11 port 0 is granted next.
//  4. sel_e held 1 after token issue, TIMEOUT=8 -> sel_r=10 held, err_timeout=1 after 8 SEND cycles; stays set until reset.
//  5. reset pulsed while sel_r=01 -> sel_r=00, grant=00, tok_cnt=0 same cycle; after release port 0 wins the next tie.
//  6. Random req/tail and random sel_e delays (1-10 cycles) -> scoreboard: no 11, no token-to-token change, fair within 1 packet.

Source files
------------

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the dual-rail select channel of a 2-input PCHB mux; holds the grant for a packet or burst.
// Latency: 1 cycle from IDLE decision to token; sel_e is seen 2 cycles late through the synchronizer.
// Backpressure: a token is held until sel_e_s falls, and the next token waits for sel_e_s to rise. sel_r returns to 00 between tokens.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-high reset (shared with the mux)
//   req[1:0]     req[i]=1: input i has a flit waiting for mux port i
//   tail[1:0]    tail[i]=1: the waiting flit on input i ends its packet
//   sel_r[1:0]   dual-rail select token: 01 = port 0, 10 = port 1, 00 = neutral
//   sel_e        mux select-channel enable (asynchronous): 1 = ready, 0 = token consumed
//   grant[1:0]   one-hot current packet owner, 00 when idle
//   busy         high in any state other than IDLE
//   tok_cnt      tokens issued in the current grant
//   err_timeout  sticky; set when a token sits unconsumed for TIMEOUT cycles
module mux_select_arbiter #(
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 5,
   parameter int TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [1:0]       tail,
   output logic [1:0]       sel_r,
   input  logic             sel_e,
   output logic [1:0]       grant,
   output logic             busy,
   output logic [CNT_W-1:0] tok_cnt,
   output logic             err_timeout
);

   // The timer must be able to hold TIMEOUT. It keeps a 1-bit width when the check is disabled.
   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [TMR_W-1:0] TMR_LIM   = TMR_W'(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RTZ  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             sel_e_m, sel_e_s;
   logic             win, win_nxt;
   logic             last_ptr, last_ptr_nxt;
   logic             rel, rel_nxt;
   logic [1:0]       sel_nxt, grant_nxt;
   logic             busy_nxt, err_nxt;
   logic [CNT_W-1:0] tok_nxt, tok_inc;
   logic [TMR_W-1:0] tmr, tmr_nxt, tmr_inc;
   logic             arb_win;

   function automatic logic [1:0] onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   // Two-flop synchronizer for the asynchronous enable.
   // The rest of the design uses only sel_e_s.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_e_m <= 1'b0;
         sel_e_s <= 1'b0;
      end else begin
         sel_e_m <= sel_e;
         sel_e_s <= sel_e_m;
      end
   end

   // A single requester wins outright. On a tie, the port that did not own the last packet wins.
   always_comb begin
      arb_win = (req == 2'b11) ? ~last_ptr : req[1];
      tok_inc = tok_cnt + CNT_ONE;
      tmr_inc = tmr + TMR_ONE;
   end

   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel_r;
      grant_nxt    = grant;
      tok_nxt      = tok_cnt;
      win_nxt      = win;
      last_ptr_nxt = last_ptr;
      rel_nxt      = rel;
      tmr_nxt      = tmr;
      err_nxt      = err_timeout;

      case (state)
         IDLE: begin
            sel_nxt = 2'b00;
            if ((req != 2'b00) && sel_e_s) begin
               win_nxt   = arb_win;
               grant_nxt = onehot(arb_win);
               sel_nxt   = onehot(arb_win);
               tok_nxt   = '0;
               tmr_nxt   = '0;
               state_nxt = SEND;
            end
         end

         SEND: begin
            // The stall timer saturates, so the error stays raised and the timer cannot wrap.
            if (TIMEOUT != 0) begin
               if (tmr != TMR_LIM) tmr_nxt = tmr_inc;
               if (tmr_inc == TMR_LIM) err_nxt = 1'b1;
            end
            // A token stays up even if req drops, because a token cannot be withdrawn.
            // The release decision is captured here and acted on in RTZ.
            if (!sel_e_s) begin
               sel_nxt   = 2'b00;
               tok_nxt   = (tok_cnt == BURST_LIM) ? tok_cnt : tok_inc;
               rel_nxt   = tail[win] | (tok_inc == BURST_LIM);
               state_nxt = RTZ;
            end
         end

         RTZ: begin
            if (sel_e_s) begin
               if (rel | ~req[win]) begin
                  grant_nxt    = 2'b00;
                  last_ptr_nxt = win;
                  state_nxt    = IDLE;
               end else begin
                  sel_nxt   = onehot(win);
                  tmr_nxt   = '0;
                  state_nxt = SEND;
               end
            end
         end

         default: begin
            sel_nxt   = 2'b00;
            grant_nxt = 2'b00;
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sel_r       <= 2'b00;
         grant       <= 2'b00;
         busy        <= 1'b0;
         tok_cnt     <= '0;
         err_timeout <= 1'b0;
         last_ptr    <= 1'b1;
         win         <= 1'b0;
         rel         <= 1'b0;
         tmr         <= '0;
      end else begin
         state       <= state_nxt;
         sel_r       <= sel_nxt;
         grant       <= grant_nxt;
         busy        <= busy_nxt;
         tok_cnt     <= tok_nxt;
         err_timeout <= err_nxt;
         last_ptr    <= last_ptr_nxt;
         win         <= win_nxt;
         rel         <= rel_nxt;
         tmr         <= tmr_nxt;
      end
   end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Testbench for mux_select_arbiter: drives packet queues and a mux-side enable responder, checks tokens against a port-level model.
// Latency: none (not a datapath).
// Backpressure: random sel_e delays emulate a slow mux.
module tb_mux_select_arbiter;
   localparam int MB = 4;
   localparam int CW = 3;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req, tail, sel_r, grant;
   logic          sel_e, busy, err_timeout;
   logic [CW-1:0] tok_cnt;

   mux_select_arbiter #(.MAX_BURST(MB), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .tail(tail), .sel_r(sel_r), .sel_e(sel_e),
      .grant(grant), .busy(busy), .tok_cnt(tok_cnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   bit         fl0[$];
   bit         fl1[$];
   bit         rand_mode;
   int         dly;
   logic [1:0] prev_sel;
   int         owner, last, cnt;
   int         waited[2];
   logic [1:0] tok_log[$];
   int         flits_in, tokens_seen;

   typedef struct {
      bit         rst;
      int         n0;
      int         n1;
      int         nexp;
      logic [7:0] ports;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] code(input int p);
      return (p == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic model_reset();
      owner = -1; last = 1; cnt = 0;
      waited[0] = 0; waited[1] = 0;
      prev_sel = 2'b00; dly = 0;
      fl0.delete(); fl1.delete();
   endtask

   task automatic drive_bufs();
      logic t0, t1;
      t0 = (fl0.size() != 0) ? fl0[0] : 1'b0;
      t1 = (fl1.size() != 0) ? fl1[0] : 1'b0;
      req  = {fl1.size() != 0, fl0.size() != 0};
      tail = {t1, t0};
   endtask

   task automatic add_pkt(input int port, input int n);
      for (int i = 0; i < n; i++) begin
         if (port == 0) fl0.push_back(i == n - 1);
         else           fl1.push_back(i == n - 1);
      end
      flits_in += n;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; sel_e = 1'b0; req = 2'b00; tail = 2'b00;
      model_reset();
      #1;
      chk("rst_sel_r", 32'(sel_r), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tok_cnt", 32'(tok_cnt), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // A new token appeared. req still holds the value the DUT sampled on its decision edge.
   task automatic on_issue();
      int p, pd;
      tok_log.push_back(sel_r);
      tokens_seen++;
      if (owner < 0) begin
         if (req == 2'b11)      p = 1 - last;
         else if (req == 2'b01) p = 0;
         else if (req == 2'b10) p = 1;
         else                   p = -1;
         if (p < 0) begin
            chk("token_without_req", 32'(sel_r), 32'd0);
            return;
         end
         pd = sel_r[1] ? 1 : 0;
         waited[pd] = 0;
         if (req == 2'b11) waited[1 - pd]++;
         else              waited[1 - pd] = 0;
         chk("fair_wait", 32'(waited[1 - pd] <= 1), 32'd1);
         owner = p;
         cnt = 0;
      end
      chk("token_port", 32'(sel_r), 32'(code(owner)));
      chk("grant_owner", 32'(grant), 32'(code(owner)));
      chk("tok_cnt_issue", 32'(tok_cnt), 32'(cnt));
      chk("busy_issue", 32'(busy), 32'd1);
   endtask

   task automatic on_consume(input logic port);
      bit tl;
      tl = 1'b0;
      if (port == 1'b0) begin
         if (fl0.size() != 0) tl = fl0.pop_front();
      end else begin
         if (fl1.size() != 0) tl = fl1.pop_front();
      end
      cnt++;
      chk("tok_cnt_consume", 32'(tok_cnt), 32'(cnt));
      if (tl || cnt == MB) begin
         last = owner;
         owner = -1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("sel_not_11", 32'(sel_r != 2'b11), 32'd1);
      chk("no_direct_change", 32'(!(prev_sel != 2'b00 && sel_r != 2'b00 && sel_r != prev_sel)), 32'd1);
      if (prev_sel == 2'b00 && sel_r != 2'b00) on_issue();
      if (prev_sel != 2'b00 && sel_r == 2'b00) on_consume(prev_sel[1]);
      // Mux side: consume a visible token, then re-arm after the token returns to neutral.
      if ((sel_e && sel_r != 2'b00) || (!sel_e && sel_r == 2'b00)) begin
         if (dly == 0) begin
            sel_e = ~sel_e;
            dly = rand_mode ? int'($urandom_range(0, 9)) : 0;
         end else begin
            dly--;
         end
      end
      if (rand_mode && $urandom_range(0, 5) == 0 && (fl0.size() + fl1.size()) < 12)
         add_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
      drive_bufs();
      prev_sel = sel_r;
   endtask

   task automatic wait_until(input int what, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if ((what == 0 && sel_r != 2'b00) || (what == 1 && sel_r == 2'b00) || (what == 2 && !busy)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok, done;
      reset = 1'b1; sel_e = 1'b0; req = 2'b00; tail = 2'b00;
      rand_mode = 1'b0; flits_in = 0; tokens_seen = 0;
      model_reset();

      // {reset first, flits on port 0, flits on port 1, token count, port of token k in bit k}
      vt[0] = '{1'b1, 1, 0, 1, 8'b0000_0000};
      vt[1] = '{1'b1, 3, 3, 6, 8'b0011_1000};
      vt[2] = '{1'b0, 2, 2, 4, 8'b0000_1100};
      vt[3] = '{1'b0, 0, 6, 6, 8'b0011_1111};
      vt[4] = '{1'b1, 1, 0, 1, 8'b0000_0000};
      vt[5] = '{1'b0, 2, 6, 8, 8'b1100_1111};
      vt[6] = '{1'b0, 1, 1, 2, 8'b0000_0010};
      vt[7] = '{1'b1, 4, 0, 4, 8'b0000_0000};

      for (int i = 0; i < 8; i++) begin
         if (vt[i].rst) do_reset();
         tok_log.delete();
         add_pkt(0, vt[i].n0);
         add_pkt(1, vt[i].n1);
         drive_bufs();
         done = 1'b0;
         for (int c = 0; c < 400; c++) begin
            step();
            if (fl0.size() == 0 && fl1.size() == 0 && !busy && sel_r == 2'b00) begin
               done = 1'b1;
               break;
            end
         end
         chk($sformatf("case%0d_done", i), 32'(done), 32'd1);
         chk($sformatf("case%0d_ntok", i), 32'(tok_log.size()), 32'(vt[i].nexp));
         chk($sformatf("case%0d_grant_idle", i), 32'(grant), 32'd0);
         for (int k = 0; k < vt[i].nexp && k < tok_log.size(); k++)
            chk($sformatf("case%0d_tok%0d", i, k), 32'(tok_log[k]), 32'(code(int'(vt[i].ports[k]))));
      end

      // Stalled token: enable never falls.
      do_reset();
      req = 2'b10; tail = 2'b00; sel_e = 1'b1;
      wait_until(0, ok);
      chk("to_token_seen", 32'(ok), 32'd1);
      chk("to_sel_r", 32'(sel_r), 32'h2);
      chk("to_grant", 32'(grant), 32'h2);
      chk("to_busy", 32'(busy), 32'd1);
      chk("to_tok_cnt", 32'(tok_cnt), 32'd0);
      repeat (7) @(negedge clk);
      chk("to_err_early", 32'(err_timeout), 32'd0);
      @(negedge clk);
      chk("to_err_set", 32'(err_timeout), 32'd1);
      chk("to_token_held", 32'(sel_r), 32'h2);
      sel_e = 1'b0;
      wait_until(1, ok);
      chk("to_consumed", 32'(ok), 32'd1);
      chk("to_tok_cnt_after", 32'(tok_cnt), 32'd1);
      req = 2'b00; sel_e = 1'b1;
      wait_until(2, ok);
      chk("to_idle", 32'(ok), 32'd1);
      chk("to_err_sticky", 32'(err_timeout), 32'd1);

      // Reset in the middle of a token. Port 0 must win the next tie.
      do_reset();
      req = 2'b01; tail = 2'b01; sel_e = 1'b1;
      wait_until(0, ok);
      chk("mr_token", 32'(sel_r), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("mr_sel_r", 32'(sel_r), 32'd0);
      chk("mr_grant", 32'(grant), 32'd0);
      chk("mr_tok_cnt", 32'(tok_cnt), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0; req = 2'b11; tail = 2'b00; sel_e = 1'b1;
      wait_until(0, ok);
      chk("mr_tie_port0", 32'(sel_r), 32'h1);
      chk("mr_tie_grant", 32'(grant), 32'h1);
      sel_e = 1'b0;
      wait_until(1, ok);
      req = 2'b00; sel_e = 1'b1;
      wait_until(2, ok);
      chk("mr_idle", 32'(ok), 32'd1);

      // Random traffic with random enable delays, checked against the model.
      do_reset();
      flits_in = 0; tokens_seen = 0;
      rand_mode = 1'b1;
      repeat (3000) step();
      rand_mode = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         step();
         if (fl0.size() == 0 && fl1.size() == 0 && !busy && sel_r == 2'b00) begin
            done = 1'b1;
            break;
         end
      end
      chk("rand_drained", 32'(done), 32'd1);
      chk("rand_tokens_eq_flits", 32'(tokens_seen), 32'(flits_in));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
